// File: rtl/regfile_pkg.sv
// Shared widths, port identifiers and the writeback request record used by the
// register-file writeback arbiter and its holding slots.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_M = 1'b1
    } port_id_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    localparam wb_req_t WB_REQ_NONE = '{valid: 1'b0, rd: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};

    // One-hot decode of a register index into a scoreboard mask.
    function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
        reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding register. Ready stays high while the slot is
// empty or is being drained this cycle, so a granted port streams every cycle.
module wb_hold_slot
    import regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output wb_req_t           o_req
);

    wb_req_t r_req;
    logic    w_accept;

    assign o_ready  = !r_req.valid || i_grant;
    assign w_accept = i_valid && o_ready;
    assign o_req    = r_req;

    // Slot storage: load on handshake, empty once the arbiter has taken it.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_req <= WB_REQ_NONE;
        end else if (w_accept) begin
            r_req <= '{valid: 1'b1, rd: i_rd, data: i_data};
        end else if (i_grant) begin
            r_req.valid <= 1'b0;
        end else begin
            r_req <= r_req;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// load writeback paths, plus the pending-destination scoreboard used by decode.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_rd,
    output logic              alloc_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              stall
);

    wb_req_t           w_req_a;
    wb_req_t           w_req_m;
    wb_req_t           w_win;
    logic              w_grant_a;
    logic              w_grant_m;
    logic              w_both;
    port_id_e          r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [NREG-1:0]   r_pending;
    logic [NREG-1:0]   w_pending_nxt;
    logic              w_alloc_ready;

    wb_hold_slot u_hold_a (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .i_valid (a_valid),
        .i_rd    (a_rd),
        .i_data  (a_data),
        .i_grant (w_grant_a),
        .o_ready (a_ready),
        .o_req   (w_req_a)
    );

    wb_hold_slot u_hold_m (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .i_valid (m_valid),
        .i_rd    (m_rd),
        .i_data  (m_data),
        .i_grant (w_grant_m),
        .o_ready (m_ready),
        .o_req   (w_req_m)
    );

    assign w_both = w_req_a.valid && w_req_m.valid;

    // Grant selection: the pointer only breaks ties when both slots hold work.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_m = 1'b0;
        w_win     = WB_REQ_NONE;
        if (w_both) begin
            if (r_ptr == PORT_A) begin
                w_grant_a = 1'b1;
            end else begin
                w_grant_m = 1'b1;
            end
        end else if (w_req_a.valid) begin
            w_grant_a = 1'b1;
        end else if (w_req_m.valid) begin
            w_grant_m = 1'b1;
        end else begin
            w_grant_a = 1'b0;
            w_grant_m = 1'b0;
        end
        if (w_grant_a) begin
            w_win = w_req_a;
        end else if (w_grant_m) begin
            w_win = w_req_m;
        end else begin
            w_win = WB_REQ_NONE;
        end
    end

    // Round-robin pointer: hand priority to the other port after a contested slot.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_ptr <= PORT_A;
        end else if (w_both) begin
            r_ptr <= (r_ptr == PORT_A) ? PORT_M : PORT_A;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Write-port register; an x0 winner still uses its slot but never strobes.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= {ADDR_W{1'b0}};
            r_wr_data <= {DATA_W{1'b0}};
        end else if (w_win.valid) begin
            r_wr_en   <= (w_win.rd != {ADDR_W{1'b0}});
            r_wr_addr <= w_win.rd;
            r_wr_data <= w_win.data;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= r_wr_addr;
            r_wr_data <= r_wr_data;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    assign w_alloc_ready = !r_pending[alloc_rd];
    assign alloc_ready   = w_alloc_ready;
    assign stall         = r_pending[rs1] | r_pending[rs2];

    // Scoreboard update: clear the committed register first so a new claim wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_wr_en) begin
            w_pending_nxt = w_pending_nxt & ~reg_onehot(r_wr_addr);
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        if (alloc_valid && w_alloc_ready) begin
            w_pending_nxt = w_pending_nxt | reg_onehot(alloc_rd);
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_pending <= {NREG{1'b0}};
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, reset sequence, then random
// traffic checked against a slot/turn reference model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              a_valid, a_ready, m_valid, m_ready;
    logic [ADDR_W-1:0] a_rd, m_rd, wr_addr, alloc_rd, rs1, rs2;
    logic [DATA_W-1:0] a_data, m_data, wr_data;
    logic              wr_en, alloc_valid, alloc_ready, stall;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter dut (
        .CLK(CLK), .RST_n(RST_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
        .rs1(rs1), .rs2(rs2), .stall(stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] ard;
        logic [DATA_W-1:0] ad;
        logic              mv;
        logic [ADDR_W-1:0] mrd;
        logic [DATA_W-1:0] md;
        logic              lv;
        logic [ADDR_W-1:0] lrd;
        logic [ADDR_W-1:0] s1;
        logic [ADDR_W-1:0] s2;
        logic              e_ardy, e_mrdy, e_lrdy, e_stall, e_we;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl[NVEC];

    // Reference model: two one-entry slots (0=ALU, 1=load), a turn marker,
    // the write-port register and a pending flag per architectural register.
    bit                sv[2];
    logic [ADDR_W-1:0] srd[2];
    logic [DATA_W-1:0] sd[2];
    int                turn;
    bit                mwe;
    logic [ADDR_W-1:0] mwa;
    logic [DATA_W-1:0] mwd;
    bit                mpend[NREG];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_valid = v.av; a_rd = v.ard; a_data = v.ad;
        m_valid = v.mv; m_rd = v.mrd; m_data = v.md;
        alloc_valid = v.lv; alloc_rd = v.lrd; rs1 = v.s1; rs2 = v.s2;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            sv[p] = 1'b0; srd[p] = '0; sd[p] = '0;
        end
        turn = 0; mwe = 1'b0; mwa = '0; mwd = '0;
        for (int r = 0; r < NREG; r++) mpend[r] = 1'b0;
    endtask

    function automatic int winner();
        if (sv[0] && sv[1]) return turn;
        if (sv[0]) return 0;
        if (sv[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        int                w;
        bit                rdy[2];
        bit                inv[2];
        logic [ADDR_W-1:0] ird[2];
        logic [DATA_W-1:0] idt[2];
        bit                alloc_ok;
        w = winner();
        inv[0] = a_valid; ird[0] = a_rd; idt[0] = a_data;
        inv[1] = m_valid; ird[1] = m_rd; idt[1] = m_data;
        for (int p = 0; p < 2; p++) rdy[p] = !sv[p] || (w == p);
        alloc_ok = !mpend[alloc_rd];
        if (mwe) mpend[mwa] = 1'b0;
        if (alloc_valid && alloc_ok && alloc_rd != 0) mpend[alloc_rd] = 1'b1;
        if (w >= 0) begin
            mwe = (srd[w] != 0);
            mwa = srd[w];
            mwd = sd[w];
            if (sv[0] && sv[1]) turn = 1 - turn;
        end else begin
            mwe = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (inv[p] && rdy[p]) begin
                sv[p] = 1'b1; srd[p] = ird[p]; sd[p] = idt[p];
            end else if (w == p) begin
                sv[p] = 1'b0;
            end
        end
    endtask

    initial begin
        //          av    ard     ad           mv    mrd    md           lv    lrd    rs1    rs2    ardy  mrdy  lrdy  stall we    wa     wd
        tbl[0]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[2]  = '{1'b1, 5'd5,  32'h1234,    1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  32'h1234};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd5,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  32'h1234};
        tbl[5]  = '{1'b1, 5'd3,  32'hAAAA,    1'b1, 5'd4,  32'hBBBB,    1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5,  32'h1234};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'hAAAA};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  32'hBBBB};
        tbl[8]  = '{1'b1, 5'd10, 32'hCCCC,    1'b1, 5'd11, 32'hDDDD,    1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4,  32'hBBBB};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 32'hDDDD};
        tbl[10] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'hCCCC};
        tbl[11] = '{1'b1, 5'd7,  32'h7777,    1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'hCCCC};
        tbl[12] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7,  32'h7777};
        tbl[13] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7,  32'h7777};
        tbl[14] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd7,  5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7,  32'h7777};
        tbl[15] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd0,  32'hFFFF,    1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7,  32'h7777};
        tbl[16] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF};
        tbl[17] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF};
        tbl[18] = '{1'b1, 5'd9,  32'h9999,    1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF};
        tbl[19] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  32'h9999};
        tbl[20] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9,  32'h9999};
        tbl[21] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0, 5'd9,  5'd9,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9,  32'h9999};
        tbl[22] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b1, 5'd0,  5'd0,  5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9,  32'h9999};
        tbl[23] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9,  32'h9999};

        a_valid = 1'b0; a_rd = '0; a_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0; rs1 = '0; rs2 = '0;
        RST_n = 1'b0;
        #1;
        chk("reset wr_en", wr_en, 1'b0);
        chk("reset wr_addr", wr_addr, 5'd0);
        chk("reset a_ready", a_ready, 1'b1);
        chk("reset m_ready", m_ready, 1'b1);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;

        // Directed table: comb outputs before the edge, write port after it.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d a_ready", i), a_ready, tbl[i].e_ardy);
            chk($sformatf("row%0d m_ready", i), m_ready, tbl[i].e_mrdy);
            chk($sformatf("row%0d alloc_ready", i), alloc_ready, tbl[i].e_lrdy);
            chk($sformatf("row%0d stall", i), stall, tbl[i].e_stall);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("row%0d wr_en", i), wr_en, tbl[i].e_we);
            chk($sformatf("row%0d wr_addr", i), wr_addr, tbl[i].e_wa);
            chk($sformatf("row%0d wr_data", i), wr_data, tbl[i].e_wd);
        end

        // Asynchronous reset with both slots full and pending[9] set.
        a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h12;
        m_valid = 1'b1; m_rd = 5'd13; m_data = 32'h13;
        alloc_valid = 1'b0; rs1 = 5'd9; rs2 = 5'd0;
        @(posedge CLK);
        @(negedge CLK);
        a_valid = 1'b0; m_valid = 1'b0;
        #1;
        chk("pre-reset m_ready", m_ready, 1'b0);
        chk("pre-reset stall", stall, 1'b1);
        RST_n = 1'b0;
        #1;
        chk("async reset wr_en", wr_en, 1'b0);
        chk("async reset wr_addr", wr_addr, 5'd0);
        chk("async reset wr_data", wr_data, 32'h0);
        chk("async reset a_ready", a_ready, 1'b1);
        chk("async reset m_ready", m_ready, 1'b1);
        chk("async reset stall", stall, 1'b0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("post-reset wr_en c%0d", c), wr_en, 1'b0);
            chk($sformatf("post-reset wr_addr c%0d", c), wr_addr, 5'd0);
        end

        // Random traffic against the reference model.
        model_reset();
        for (int c = 0; c < 400; c++) begin
            int w;
            a_valid = ($urandom_range(0, 9) < 7);
            a_rd = ADDR_W'($urandom_range(0, 7));
            a_data = $urandom;
            m_valid = ($urandom_range(0, 9) < 6);
            m_rd = ADDR_W'($urandom_range(0, 7));
            m_data = $urandom;
            alloc_valid = ($urandom_range(0, 9) < 4);
            alloc_rd = ADDR_W'($urandom_range(0, 7));
            rs1 = ADDR_W'($urandom_range(0, 7));
            rs2 = ADDR_W'($urandom_range(0, 7));
            #1;
            w = winner();
            chk($sformatf("rnd%0d a_ready", c), a_ready, !sv[0] || (w == 0));
            chk($sformatf("rnd%0d m_ready", c), m_ready, !sv[1] || (w == 1));
            chk($sformatf("rnd%0d alloc_ready", c), alloc_ready, !mpend[alloc_rd]);
            chk($sformatf("rnd%0d stall", c), stall, mpend[rs1] | mpend[rs2]);
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            chk($sformatf("rnd%0d wr_en", c), wr_en, mwe);
            chk($sformatf("rnd%0d wr_addr", c), wr_addr, mwa);
            chk($sformatf("rnd%0d wr_data", c), wr_data, mwd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU (port A) and load/memory (port M).
- Each requester connects through a valid/ready handshake backed by a one-entry holding register.
- Arbitration is round-robin; the arbiter drives a registered write strobe, address and data into the register file.
- It also keeps a per-register pending scoreboard. Decode uses this scoreboard to detect RAW hazards and to refuse WAW double-allocation.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, register address width
NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_n  input  1  asynchronous active-low reset
a_valid  input  1  ALU writeback request
a_ready  output  1  ALU request accepted this cycle when high with a_valid
a_rd  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
m_valid  input  1  memory writeback request
m_ready  output  1  memory request accepted when high with m_valid
m_rd  input  ADDR_W  memory destination register
m_data  input  DATA_W  load data
wr_en  output  1  register-file write strobe (registered)
wr_addr  output  ADDR_W  register-file write address (registered)
wr_data  output  DATA_W  register-file write data (registered)
alloc_valid  input  1  decode claims rd as future destination
alloc_rd  input  ADDR_W  register being claimed
alloc_ready  output  1  claim accepted (0 if alloc_rd already pending)
rs1  input  ADDR_W  source query 1
rs2  input  ADDR_W  source query 2
stall  output  1  rs1 or rs2 pending (combinational)

Behaviour:
- Reset (RST_n low, asynchronous):
  - both holding registers become invalid;
  - wr_en=0, wr_addr=0, wr_data=0;
  - pending vector = all zeros;
  - round-robin pointer = A;
  - a_ready=1, m_ready=1.
- Reset mid-operation discards held requests and any in-flight write; no write is issued after reset release until new requests arrive.
- Holding registers hA and hM:
  - each captures rd and data at a rising edge where valid&ready is high;
  - a_ready = !hA.valid || grantA (same for M), so a fully pipelined stream sustains one accept per cycle per port when that port is granted.
- Arbitration is combinational on holding-register valids:
  - only one valid: grant it;
  - both valid: grant the port the pointer names, then move the pointer to the other port at that edge;
  - pointer changes only when both are valid.
- Output register loads at every edge:
  - wr_en = any grant;
  - wr_addr/wr_data = granted entry;
  - with no grant, wr_en=0 and wr_addr/wr_data hold their previous values.
- Latency: a handshake at edge k gives wr_en high in the cycle after edge k+1 when uncontested. Each contention loss adds one cycle.
- rd==0:
  - the request is accepted and arbitrated normally;
  - wr_en stays 0 for that slot; x0 is never written;
  - it consumes its grant slot, and the pointer still toggles.
- Scoreboard pending[NREG-1:0]:
  - pending[0] is always 0; alloc of rd 0 is accepted with no effect.
  - alloc_ready = !pending[alloc_rd]. At an edge with alloc_valid&alloc_ready, pending[alloc_rd] is set.
  - pending[wr_addr] clears at the edge ending the cycle in which wr_en=1. This guarantees the register file's write in that cycle has completed.
  - Same-edge set of reg r and clear of reg r: set wins. This is reachable only for a new claim after a commit, because alloc_ready is computed from the pre-edge pending value.
  - stall = pending[rs1] | pending[rs2]. The block never checks that a commit has a matching alloc; that is the caller's contract.
- Width: data is passed through unmodified; no arithmetic on DATA_W.

Decomposition:
- Shared package regfile_pkg: DATA_W, ADDR_W and NREG constants; a port-id constant (PORT_A=0, PORT_M=1); a wb_req struct {valid, rd, data}.
- One natural sub-module: wb_hold_slot, the one-entry holding register with valid/ready. It is instantiated twice.
- The arbiter and scoreboard stay in the top module.

Test Plan:
- Reset: drive RST_n low mid-stream with hA valid -> wr_en=0, wr_addr=0, pending=0, a_ready=m_ready=1 immediately (asynchronous).
- Single ALU write: a_valid, rd=5, data=0x1234 at edge k -> wr_en=1, wr_addr=5, wr_data=0x1234 in cycle after edge k+1.
- Contention: A (rd=3, 0xAAAA) and M (rd=4, 0xBBBB) valid together from reset -> rd 3 written first, rd 4 next cycle. Repeat with both -> M-side written first (pointer toggled).
- x0 suppression: m_valid, rd=0, data=0xFFFF -> accepted (m_ready=1), wr_en stays 0, pending[0]=0.
- Scoreboard: alloc rd=7 -> stall=1 with rs1=7. Second alloc rd=7 -> alloc_ready=0. After an A commit to rd=7, stall drops at the edge ending the wr_en cycle.
- Same-edge set/clear: commit to rd=9 in a cycle where alloc rd=9 is presented (pending[9] was 0) -> pending[9]=1 after that edge.
